// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge port: one request outstanding at most.
interface if_fetch_ctrl_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: PC register, req/ack imem port, one-deep skid and redirects.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             Z,
    input  logic             J,
    input  logic             JR,
    input  logic [31:0]      JumpAddr,
    input  logic [31:0]      JrAddr,
    input  logic [31:0]      BranchAddr,
    if_fetch_ctrl_if.master  imem,
    output logic [31:0]      Instruction_if,
    output logic [31:0]      PC,
    output logic [31:0]      NextPC_if,
    output logic             if_valid,
    output logic             flush_id,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FULL,
        ST_DISCARD
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    fetch_entry_t    skid;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic            slot_free_c;
    logic            consume_c;
    logic            ack_c;
    logic [XLEN-1:0] addr_plus4_c;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Redirect priority JR > J > branch.
    assign redirect_c   = JR | J | Z;
    assign target_c     = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
    assign slot_free_c  = !if_valid || !stall;
    assign consume_c    = if_valid && !stall;
    assign ack_c        = imem.imem_ack;
    assign addr_plus4_c = addr_q + XLEN'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            fetch_pc       <= RESET_PC;
            req_q          <= 1'b0;
            addr_q         <= RESET_PC;
            Instruction_if <= '0;
            PC             <= RESET_PC;
            NextPC_if      <= RESET_PC + XLEN'(4);
            if_valid       <= 1'b0;
            flush_id       <= 1'b0;
            skid           <= '0;
        end else begin
            flush_id <= 1'b0;
            if (redirect_c) begin
                // Redirect wins over stall and over any data returning this cycle.
                fetch_pc <= target_c;
                flush_id <= 1'b1;
                if_valid <= 1'b0;
                skid     <= '0;
                case (state)
                    ST_REQ: begin
                        if (ack_c) addr_q <= target_c;
                        else       state  <= ST_DISCARD;
                    end
                    ST_DISCARD: begin
                        if (ack_c) begin
                            state  <= ST_REQ;
                            addr_q <= target_c;
                        end
                    end
                    default: begin
                        state  <= ST_REQ;
                        req_q  <= 1'b1;
                        addr_q <= target_c;
                    end
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        state  <= ST_REQ;
                        req_q  <= 1'b1;
                        addr_q <= fetch_pc;
                        if (consume_c) if_valid <= 1'b0;
                    end
                    ST_REQ: begin
                        if (ack_c) begin
                            fetch_pc <= addr_plus4_c;
                            addr_q   <= addr_plus4_c;
                            if (slot_free_c) begin
                                Instruction_if <= imem.imem_rdata;
                                PC             <= addr_q;
                                NextPC_if      <= addr_plus4_c;
                                if_valid       <= 1'b1;
                            end else begin
                                // ID is holding the slot: park the word and pause requests.
                                skid.instr <= imem.imem_rdata;
                                skid.pc    <= addr_q;
                                state      <= ST_FULL;
                                req_q      <= 1'b0;
                            end
                        end else if (consume_c) begin
                            if_valid <= 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (!stall) begin
                            Instruction_if <= skid.instr;
                            PC             <= skid.pc;
                            NextPC_if      <= skid.pc + XLEN'(4);
                            skid           <= '0;
                            state          <= ST_REQ;
                            req_q          <= 1'b1;
                            addr_q         <= fetch_pc;
                        end
                    end
                    ST_DISCARD: begin
                        // Abandoned request completes; its data is dropped.
                        if (ack_c) begin
                            state  <= ST_REQ;
                            addr_q <= fetch_pc;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc_c;
    logic stall_inc_c;

    assign fetch_inc_c = (state == ST_REQ) && ack_c && !redirect_c;
    assign stall_inc_c = if_valid && stall;

    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_inc_c && (perf_fetch_cnt != '1))
                perf_fetch_cnt <= perf_fetch_cnt + CNT_W'(1);
            if (stall_inc_c && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (redirect_c && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl, plus a second instance started at the top of the address space.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall, Z, J, JR;
    logic [31:0] JumpAddr, JrAddr, BranchAddr;
    logic [31:0] Instruction_if, PC, NextPC_if;
    logic        if_valid, flush_id;
    logic [15:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;

    logic [31:0] w_instr, w_pc, w_npc;
    logic        w_valid, w_flush;
    logic [15:0] w_pf, w_ps, w_pfl;

    if_fetch_ctrl_if mif();
    if_fetch_ctrl_if wif();

    always #5 clk = ~clk;

    if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .Z(Z), .J(J), .JR(JR),
        .JumpAddr(JumpAddr), .JrAddr(JrAddr), .BranchAddr(BranchAddr),
        .imem(mif),
        .Instruction_if(Instruction_if), .PC(PC), .NextPC_if(NextPC_if),
        .if_valid(if_valid), .flush_id(flush_id),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) u_wrap (
        .clk(clk), .reset(reset), .stall(1'b0), .Z(1'b0), .J(1'b0), .JR(1'b0),
        .JumpAddr(32'h0), .JrAddr(32'h0), .BranchAddr(32'h0),
        .imem(wif),
        .Instruction_if(w_instr), .PC(w_pc), .NextPC_if(w_npc),
        .if_valid(w_valid), .flush_id(w_flush),
        .perf_fetch_cnt(w_pf), .perf_stall_cnt(w_ps), .perf_flush_cnt(w_pfl)
    );

    // Memory: word at addr reads as addr + 0x1000_0000, after cur_wait cycles of request.
    int unsigned wcnt, rnd_wait, fixed_wait, cur_wait;
    logic        mem_go, rand_wait;

    assign cur_wait       = rand_wait ? rnd_wait : fixed_wait;
    assign mif.imem_ack   = mif.imem_req && mem_go && (wcnt >= cur_wait);
    assign mif.imem_rdata = mif.imem_addr + 32'h1000_0000;
    assign wif.imem_ack   = wif.imem_req;
    assign wif.imem_rdata = wif.imem_addr + 32'h1000_0000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt     <= 0;
            rnd_wait <= 0;
        end else if (mif.imem_ack) begin
            wcnt     <= 0;
            rnd_wait <= $urandom_range(0, 3);
        end else if (mif.imem_req) begin
            wcnt <= wcnt + 1;
        end
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        stall = 1'b0; Z = 1'b0; J = 1'b0; JR = 1'b0;
        JumpAddr = '0; JrAddr = '0; BranchAddr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clr_inputs();
        mem_go = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, nflush, delivered;
        logic        moved, redir, flush_due, hold_due;
        logic [31:0] exp_pc, target, prev_addr;
        int unsigned r;

        reset = 1'b1; clr_inputs();
        mem_go = 1'b1; rand_wait = 1'b0; fixed_wait = 0;
        repeat (2) @(negedge clk);
        check32("rst_pc", PC, 32'h0);
        check32("rst_npc", NextPC_if, 32'h4);
        check32("rst_instr", Instruction_if, 32'h0);
        check1("rst_valid", if_valid, 1'b0);
        check1("rst_flush", flush_id, 1'b0);
        check1("rst_req", mif.imem_req, 1'b0);
        check32("rst_addr", mif.imem_addr, 32'h0);
        check32("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        check32("rst_wrap_npc", w_npc, 32'h0);
        reset = 1'b0;

        // Zero-wait streaming.
        tick();
        check1("zw_valid_c1", if_valid, 1'b0);
        check1("zw_req_c1", mif.imem_req, 1'b1);
        tick();
        check1("zw_valid_c2", if_valid, 1'b1);
        check32("zw_pc0", PC, 32'h0);
        check32("zw_instr0", Instruction_if, 32'h1000_0000);
        check32("zw_npc0", NextPC_if, 32'h4);
        check32("wrap_pc0", w_pc, 32'hFFFF_FFFC);
        check32("wrap_npc0", w_npc, 32'h0);
        check32("wrap_instr0", w_instr, 32'h0FFF_FFFC);
        tick();
        check32("zw_pc4", PC, 32'h4);
        check32("zw_npc4", NextPC_if, 32'h8);
        check32("wrap_pc1", w_pc, 32'h0);
        check32("wrap_npc1", w_npc, 32'h4);
        check1("wrap_flush", w_flush, 1'b0);
        tick();
        check32("zw_pc8", PC, 32'h8);

        // Stall for three cycles with PC=8 in the slot.
        stall = 1'b1;
        tick();
        check32("st_pc_hold1", PC, 32'h8);
        check1("st_req_full1", mif.imem_req, 1'b0);
        tick();
        check1("st_req_full2", mif.imem_req, 1'b0);
        tick();
        check32("st_pc_hold3", PC, 32'h8);
        check1("st_valid_hold", if_valid, 1'b1);
        stall = 1'b0;
        tick();
        check32("st_pc_c", PC, 32'hC);
        check32("st_instr_c", Instruction_if, 32'h1000_000C);
        check32("st_addr_10", mif.imem_addr, 32'h10);
        tick();
        check32("st_pc_10", PC, 32'h10);
        tick();
        check32("st_pc_14", PC, 32'h14);

        // Three wait states, jump while the request for 8 is outstanding.
        fixed_wait = 3;
        do_reset();
        k = 0;
        while (!(mif.imem_req && mif.imem_addr == 32'h8) && k < 40) begin tick(); k++; end
        check1("j_req8_seen", k < 40, 1'b1);
        tick();
        J = 1'b1; JumpAddr = 32'h40;
        tick();
        check1("j_flush", flush_id, 1'b1);
        check1("j_valid", if_valid, 1'b0);
        check32("j_addr_hold", mif.imem_addr, 32'h8);
        check1("j_req_hold", mif.imem_req, 1'b1);
        J = 1'b0;
        k = 0; nflush = 0; moved = 1'b0;
        while (!mif.imem_ack && k < 20) begin
            tick(); k++;
            if (flush_id) nflush++;
            if (mif.imem_addr != 32'h8) moved = 1'b1;
        end
        check1("j_ack_seen", k < 20, 1'b1);
        check32("j_flush_once", 32'(nflush), 32'h0);
        check1("j_addr_stable", moved, 1'b0);
        tick();
        check32("j_next_addr", mif.imem_addr, 32'h40);
        check1("j_next_req", mif.imem_req, 1'b1);
        check1("j_dropped", if_valid, 1'b0);
        k = 0;
        while (!if_valid && k < 20) begin tick(); k++; end
        check32("j_first_pc", PC, 32'h40);

        // Simultaneous JR, J and Z.
        fixed_wait = 0;
        do_reset();
        tick(); tick();
        JR = 1'b1; J = 1'b1; Z = 1'b1;
        JrAddr = 32'h80; JumpAddr = 32'h40; BranchAddr = 32'h20;
        tick();
        check32("prio_addr", mif.imem_addr, 32'h80);
        check1("prio_flush", flush_id, 1'b1);
        check1("prio_valid", if_valid, 1'b0);
        clr_inputs();
        tick();
        check32("prio_pc", PC, 32'h80);

        // Branch together with an ack while ID stalls.
        stall = 1'b1; Z = 1'b1; BranchAddr = 32'h200;
        tick();
        check1("bra_valid", if_valid, 1'b0);
        check1("bra_flush", flush_id, 1'b1);
        check32("bra_addr", mif.imem_addr, 32'h200);
        clr_inputs();
        tick();
        check32("bra_pc", PC, 32'h200);

        // Jump while the skid is full.
        stall = 1'b1;
        tick();
        check1("skid_req_off", mif.imem_req, 1'b0);
        J = 1'b1; JumpAddr = 32'h300;
        tick();
        check1("skid_valid", if_valid, 1'b0);
        check1("skid_flush", flush_id, 1'b1);
        check32("skid_addr", mif.imem_addr, 32'h300);
        check1("skid_req", mif.imem_req, 1'b1);
        clr_inputs();
        tick();
        check32("skid_pc_a", PC, 32'h300);
        tick();
        check32("skid_pc_b", PC, 32'h304);

        // Counters: 5 fetches, 2 stall cycles, 1 redirect.
        do_reset();
        repeat (6) tick();
        check32("perf_pc", PC, 32'h10);
        mem_go = 1'b0; stall = 1'b1;
        tick(); tick();
        stall = 1'b0; J = 1'b1; JumpAddr = 32'h40;
        tick();
        J = 1'b0; mem_go = 1'b1;
`ifdef FETCH_PERF_CNT_EN
        check32("perf_fetch", 32'(perf_fetch_cnt), 32'd5);
        check32("perf_stall", 32'(perf_stall_cnt), 32'd2);
        check32("perf_flush", 32'(perf_flush_cnt), 32'd1);
`else
        check32("perf_fetch", 32'(perf_fetch_cnt), 32'd0);
        check32("perf_stall", 32'(perf_stall_cnt), 32'd0);
        check32("perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif

        // Random stalls, wait states and redirects against the delivered-stream model.
        rand_wait = 1'b1;
        do_reset();
        exp_pc = 32'h0; delivered = 0; flush_due = 1'b0; hold_due = 1'b0; prev_addr = '0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            tick();
            check1("rnd_flush", flush_id, flush_due);
            if (flush_due) check1("rnd_flush_valid", if_valid, 1'b0);
            if (hold_due) begin
                check1("rnd_req_hold", mif.imem_req, 1'b1);
                check32("rnd_addr_hold", mif.imem_addr, prev_addr);
            end
            if (if_valid) begin
                check32("rnd_npc", NextPC_if, PC + 32'd4);
                check32("rnd_instr", Instruction_if, PC + 32'h1000_0000);
            end
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 11) == 0);
            r = redir ? $urandom_range(1, 7) : 0;
            JR = r[2]; J = r[1]; Z = r[0];
            JrAddr     = $urandom & 32'hFFFF_FFFC;
            JumpAddr   = $urandom & 32'hFFFF_FFFC;
            BranchAddr = $urandom & 32'hFFFF_FFFC;
            target = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
            if (redir) begin
                exp_pc = target;
            end else if (if_valid && !stall) begin
                check32("rnd_pc", PC, exp_pc);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            flush_due = redir;
            #1;
            hold_due  = mif.imem_req && !mif.imem_ack;
            prev_addr = mif.imem_addr;
        end
        clr_inputs();
        check1("rnd_progress", delivered > 100, 1'b1);
        check32("wrap_no_flush_cnt", 32'(w_pfl), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
